pc_next_sequencer: RTL and testbench
====================================

Name: pc_next_sequencer

Overview:
- Producer side of the program-counter interface: generates the next-PC value driven into the PC register's _PC input every cycle.
- Sequential increment, branch/jump redirect via valid/ack handshake, stall hold, halt/resume, and trap on misaligned targets.
- Sits between the branch/jump resolution logic and the PC register, at the front of the fetch path.

Parameters:
- RESET_VEC, 32'h0000_0000, first PC issued after reset.
- TRAP_VEC, 32'h0000_0100, PC substituted for a misaligned branch target.
- STEP, 4, increment per cycle in bytes.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- STALL  in  1  hold NEXT_PC this cycle.
- BR_VALID  in  1  redirect request; held with BR_TARGET stable until BR_ACK.
- BR_TARGET  in  32  redirect address.
- HALT_REQ  in  1  enter HALT.
- RESUME  in  1  leave HALT.
- NEXT_PC  out  32  value for the PC register _PC input.
- PC_VALID  out  1  NEXT_PC is a live fetch address.
- BR_ACK  out  1  one-cycle pulse; redirect accepted.
- HALTED  out  1  high in HALT.
- MISALIGN_ERR  out  1  sticky; a misaligned target was seen.

Behaviour:
- Reset (RST_N low, async): state BOOT, NEXT_PC=RESET_VEC, PC_VALID=0, BR_ACK=0, HALTED=0, MISALIGN_ERR=0.
- All outputs are registered. State changes take effect on the rising CLK edge after the inputs are sampled.
- BOOT: first edge after reset release -> RUN. PC_VALID=1, NEXT_PC stays RESET_VEC.
- RUN, priority per edge:
  - HALT_REQ -> HALT, NEXT_PC held.
  - Else STALL -> hold everything. BR_ACK=0; a pending branch stays pending.
  - Else BR_VALID and !BR_ACK -> redirect. NEXT_PC=BR_TARGET if BR_TARGET[1:0]==0; otherwise NEXT_PC=TRAP_VEC and MISALIGN_ERR set (sticky until reset). BR_ACK=1 for exactly one cycle in both cases.
  - Else NEXT_PC=NEXT_PC+STEP, modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
- BR_VALID is ignored in the cycle BR_ACK is high. The initiator drops or changes the request in that cycle, so one request never yields two acks.
- HALT: PC_VALID=0, HALTED=1, NEXT_PC frozen, BR_VALID not acknowledged.
- RESUME in HALT -> RUN on the next edge. PC_VALID=1 with the frozen NEXT_PC; incrementing resumes the following edge.
- HALT_REQ and RESUME both high in HALT: stay in HALT.
- Reset mid-operation: immediate return to reset values. A pending branch is dropped without ack.
- STALL during BOOT: ignored; BOOT always lasts one cycle.
- Implementation uses a 2-bit state register (BOOT, RUN, HALT). STATE encoding is not externally visible.

Test Plan:
- Reset then release, no other inputs -> NEXT_PC 0,0,4,8,12 on successive edges. PC_VALID rises with the first RUN cycle.
- At NEXT_PC=12, BR_VALID=1, BR_TARGET=32 until ack -> next NEXT_PC=32, single BR_ACK pulse, then 36, 40.
- STALL high 3 cycles at NEXT_PC=8 while BR_VALID=1, target 0x40 -> NEXT_PC holds 8, no ack. The edge after STALL drops gives NEXT_PC=0x40 and BR_ACK=1.
- BR_TARGET=0x22 -> NEXT_PC=0x100, MISALIGN_ERR=1 and stays 1. Next edge NEXT_PC=0x104.
- HALT_REQ at NEXT_PC=0x10 -> HALTED=1, PC_VALID=0, value frozen for 5 cycles with a branch pending (no ack). RESUME -> PC_VALID=1 at 0x10, then the branch is taken.
- Force NEXT_PC to 0xFFFF_FFFC via branch -> next NEXT_PC 0x0. Assert RST_N low mid-stall -> all outputs at reset values immediately.

Source files
------------

// File: rtl/pc_next_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_next_sequencer
// Purpose  : Next-PC producer for the fetch path. Issues RESET_VEC after reset,
//            then increments by STEP each cycle. Redirects to a branch/jump
//            target through a valid/ack handshake and holds the PC on stall.
//            Supports halt/resume. A misaligned target is replaced by
//            TRAP_VEC and raises a sticky error flag.
// Ports    : clk          - system clock, rising edge
//            rst_n        - asynchronous active-low reset
//            stall        - hold next_pc this cycle
//            br_valid     - redirect request, held with br_target until ack
//            br_target    - redirect address
//            halt_req     - enter HALT
//            resume       - leave HALT
//            next_pc      - value for the PC register input
//            pc_valid     - next_pc is a live fetch address
//            br_ack       - one-cycle pulse, redirect accepted
//            halted       - high while in HALT
//            misalign_err - sticky, a misaligned target was seen
// Revision : 1.0 - initial release
// ============================================================================
module pc_next_sequencer #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC  = 32'h0000_0100,
  parameter logic [31:0] STEP      = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic        halt_req,
  input  logic        resume,
  output logic [31:0] next_pc,
  output logic        pc_valid,
  output logic        br_ack,
  output logic        halted,
  output logic        misalign_err
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  logic [1:0]  state_q,        state_d;
  logic [31:0] next_pc_q,      next_pc_d;
  logic        pc_valid_q,     pc_valid_d;
  logic        br_ack_q,       br_ack_d;
  logic        halted_q,       halted_d;
  logic        misalign_err_q, misalign_err_d;

  logic        target_aligned;

  assign target_aligned = (br_target[1:0] == 2'b00);

  always_comb begin
    state_d        = state_q;
    next_pc_d      = next_pc_q;
    pc_valid_d     = pc_valid_q;
    br_ack_d       = 1'b0;          // ack is a single-cycle pulse
    halted_d       = halted_q;
    misalign_err_d = misalign_err_q;

    case (state_q)
      ST_BOOT: begin
        // BOOT always lasts exactly one cycle; stall has no effect here.
        state_d    = ST_RUN;
        pc_valid_d = 1'b1;
        halted_d   = 1'b0;
      end

      ST_RUN: begin
        if (halt_req) begin
          state_d    = ST_HALT;
          pc_valid_d = 1'b0;
          halted_d   = 1'b1;
        end else if (stall) begin
          // Hold PC; a pending request stays pending because ack stays low.
        end else if (br_valid && !br_ack_q) begin
          // The request is still asserted during its own ack cycle, so the
          // ack qualifier prevents one request from being taken twice.
          br_ack_d = 1'b1;
          if (target_aligned) begin
            next_pc_d = br_target;
          end else begin
            next_pc_d      = TRAP_VEC;
            misalign_err_d = 1'b1;
          end
        end else begin
          next_pc_d = next_pc_q + STEP;
        end
      end

      ST_HALT: begin
        // halt_req wins over resume when both are asserted.
        if (resume && !halt_req) begin
          state_d    = ST_RUN;
          pc_valid_d = 1'b1;
          halted_d   = 1'b0;
        end
      end

      default: begin
        // Unreachable encoding: restart cleanly from BOOT.
        state_d    = ST_BOOT;
        next_pc_d  = RESET_VEC;
        pc_valid_d = 1'b0;
        halted_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_BOOT;
      next_pc_q      <= RESET_VEC;
      pc_valid_q     <= 1'b0;
      br_ack_q       <= 1'b0;
      halted_q       <= 1'b0;
      misalign_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      next_pc_q      <= next_pc_d;
      pc_valid_q     <= pc_valid_d;
      br_ack_q       <= br_ack_d;
      halted_q       <= halted_d;
      misalign_err_q <= misalign_err_d;
    end
  end

  assign next_pc      = next_pc_q;
  assign pc_valid     = pc_valid_q;
  assign br_ack       = br_ack_q;
  assign halted       = halted_q;
  assign misalign_err = misalign_err_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_next_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_next_sequencer
// Purpose  : Self-checking bench for pc_next_sequencer. Directed scenarios
//            with constant expectations, followed by randomized traffic
//            compared against a behavioural model of the sequencer.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_next_sequencer;

  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;
  localparam int          STEP      = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        br_valid = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        halt_req = 1'b0;
  logic        resume = 1'b0;
  logic [31:0] next_pc;
  logic        pc_valid;
  logic        br_ack;
  logic        halted;
  logic        misalign_err;

  int errors = 0;
  int checks = 0;

  pc_next_sequencer #(
    .RESET_VEC (RESET_VEC),
    .TRAP_VEC  (TRAP_VEC),
    .STEP      (STEP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .br_valid     (br_valid),
    .br_target    (br_target),
    .halt_req     (halt_req),
    .resume       (resume),
    .next_pc      (next_pc),
    .pc_valid     (pc_valid),
    .br_ack       (br_ack),
    .halted       (halted),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  // Observed outputs packed as {pc, valid, ack, halted, err}.
  logic [35:0] obs;
  assign obs = {next_pc, pc_valid, br_ack, halted, misalign_err};

  function automatic logic [35:0] pack(input logic [31:0] pc, input logic v,
                                       input logic a, input logic h,
                                       input logic e);
    return {pc, v, a, h, e};
  endfunction

  // ---------------- behavioural reference model ----------------
  bit          m_fresh;    // first cycle after reset release still pending
  bit          m_stopped;  // in halt
  longint      m_pc;
  bit          m_live;
  bit          m_ack;
  bit          m_err;

  task automatic model_reset();
    m_fresh = 1; m_stopped = 0; m_pc = RESET_VEC;
    m_live = 0; m_ack = 0; m_err = 0;
  endtask

  task automatic model_step();
    bit took;
    took = 0;
    if (m_fresh) begin
      m_fresh = 0;
      m_live  = 1;
    end else if (m_stopped) begin
      if (resume && !halt_req) begin
        m_stopped = 0;
        m_live    = 1;
      end
    end else if (halt_req) begin
      m_stopped = 1;
      m_live    = 0;
    end else if (stall) begin
      took = 0;
    end else if (br_valid && !m_ack) begin
      took = 1;
      if (br_target % 4 == 0) m_pc = br_target;
      else begin
        m_pc  = TRAP_VEC;
        m_err = 1;
      end
    end else begin
      m_pc = (m_pc + STEP) % 64'h1_0000_0000;
    end
    m_ack = took;
  endtask

  function automatic logic [35:0] model_vec();
    return pack(m_pc[31:0], m_live, m_ack, m_stopped, m_err);
  endfunction

  // One clock: model sees the same inputs the DUT samples.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; stall = 0; br_valid = 0; br_target = 0;
    halt_req = 0; resume = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] pcs [4];
    logic [35:0] exp;
    pcs = '{32'd0, 32'd4, 32'd8, 32'd12};
    @(negedge clk);
    rst_n = 1'b0; stall = 0; br_valid = 0; halt_req = 0; resume = 0;
    model_reset();
    #1;
    exp = pack(RESET_VEC, 0, 0, 0, 0);
    checks++;
    if (obs !== exp) begin
      errors++; $display("FAIL reset_values: got %h want %h", obs, exp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (obs !== exp) begin
      errors++; $display("FAIL reset_release: got %h want %h", obs, exp);
    end
    for (int i = 0; i < 4; i++) begin
      cycle();
      exp = pack(pcs[i], 1, 0, 0, 0);
      checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL seq_step%0d: got %h want %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_branch();
    logic [35:0] exp;
    br_valid = 1; br_target = 32'd32;
    cycle();
    exp = pack(32'd32, 1, 1, 0, 0);
    checks++;
    if (obs !== exp) begin
      errors++; $display("FAIL branch_take: got %h want %h", obs, exp);
    end
    br_valid = 0;
    cycle();
    exp = pack(32'd36, 1, 0, 0, 0);
    checks++;
    if (obs !== exp) begin
      errors++; $display("FAIL branch_next1: got %h want %h", obs, exp);
    end
    cycle();
    exp = pack(32'd40, 1, 0, 0, 0);
    checks++;
    if (obs !== exp) begin
      errors++; $display("FAIL branch_next2: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_stall_branch();
    logic [35:0] exp;
    apply_reset();
    repeat (3) cycle();
    stall = 1; br_valid = 1; br_target = 32'h40;
    for (int i = 0; i < 3; i++) begin
      cycle();
      exp = pack(32'd8, 1, 0, 0, 0);
      checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL stall_hold%0d: got %h want %h", i, obs, exp);
      end
    end
    stall = 0;
    cycle();
    exp = pack(32'h40, 1, 1, 0, 0);
    checks++;
    if (obs !== exp) begin
      errors++; $display("FAIL stall_release_branch: got %h want %h", obs, exp);
    end
    br_valid = 0;
    cycle();
    exp = pack(32'h44, 1, 0, 0, 0);
    checks++;
    if (obs !== exp) begin
      errors++; $display("FAIL stall_after_ack: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_misalign();
    logic [35:0] exp;
    br_valid = 1; br_target = 32'h22;
    cycle();
    exp = pack(TRAP_VEC, 1, 1, 0, 1);
    checks++;
    if (obs !== exp) begin
      errors++; $display("FAIL misalign_trap: got %h want %h", obs, exp);
    end
    br_valid = 0;
    for (int i = 1; i <= 2; i++) begin
      cycle();
      exp = pack(TRAP_VEC + 32'(4 * i), 1, 0, 0, 1);
      checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL misalign_sticky%0d: got %h want %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_halt();
    logic [35:0] exp;
    apply_reset();
    repeat (5) cycle();
    exp = pack(32'h10, 1, 0, 0, 0);
    checks++;
    if (obs !== exp) begin
      errors++; $display("FAIL halt_pre: got %h want %h", obs, exp);
    end
    halt_req = 1;
    cycle();
    exp = pack(32'h10, 0, 0, 1, 0);
    checks++;
    if (obs !== exp) begin
      errors++; $display("FAIL halt_enter: got %h want %h", obs, exp);
    end
    halt_req = 0; br_valid = 1; br_target = 32'h80;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        halt_req = 1; resume = 1;   // both high: must stay halted
      end
      cycle();
      checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL halt_frozen%0d: got %h want %h", i, obs, exp);
      end
    end
    halt_req = 0; resume = 1;
    cycle();
    exp = pack(32'h10, 1, 0, 0, 0);
    checks++;
    if (obs !== exp) begin
      errors++; $display("FAIL halt_resume: got %h want %h", obs, exp);
    end
    resume = 0;
    cycle();
    exp = pack(32'h80, 1, 1, 0, 0);
    checks++;
    if (obs !== exp) begin
      errors++; $display("FAIL halt_pending_branch: got %h want %h", obs, exp);
    end
    br_valid = 0;
    cycle();
    exp = pack(32'h84, 1, 0, 0, 0);
    checks++;
    if (obs !== exp) begin
      errors++; $display("FAIL halt_after_branch: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_wrap_and_async_reset();
    logic [35:0] exp;
    br_valid = 1; br_target = 32'hFFFF_FFFC;
    cycle();
    exp = pack(32'hFFFF_FFFC, 1, 1, 0, 0);
    checks++;
    if (obs !== exp) begin
      errors++; $display("FAIL wrap_branch: got %h want %h", obs, exp);
    end
    br_valid = 0;
    cycle();
    exp = pack(32'h0, 1, 0, 0, 0);
    checks++;
    if (obs !== exp) begin
      errors++; $display("FAIL wrap_zero: got %h want %h", obs, exp);
    end
    cycle();
    stall = 1; br_valid = 1; br_target = 32'h200;
    cycle();
    exp = pack(32'h4, 1, 0, 0, 0);
    checks++;
    if (obs !== exp) begin
      errors++; $display("FAIL wrap_stall: got %h want %h", obs, exp);
    end
    #2;
    rst_n = 0;
    model_reset();
    #1;
    exp = pack(RESET_VEC, 0, 0, 0, 0);
    checks++;
    if (obs !== exp) begin
      errors++; $display("FAIL async_reset: got %h want %h", obs, exp);
    end
    @(negedge clk);
    stall = 0; br_valid = 0;
    rst_n = 1;
  endtask

  task automatic test_random();
    logic [31:0] t;
    logic [35:0] exp;
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      stall    = ($urandom_range(0, 3) == 0);
      halt_req = ($urandom_range(0, 19) == 0);
      resume   = ($urandom_range(0, 2) == 0);
      // Keep a not-yet-acknowledged request stable; otherwise drop or renew.
      if (!(br_valid && !m_ack)) begin
        br_valid = ($urandom_range(0, 2) == 0);
        t = $urandom;
        if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
        br_target = t;
      end
      cycle();
      exp = model_vec();
      checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL random_cycle%0d: got %h want %h", i, obs, exp);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_branch();
    test_stall_branch();
    test_misalign();
    test_halt();
    test_wrap_and_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
